// File: rtl/fx_pkg.sv
// Shared types and Q-format helpers for the sequential fixed-point divider.
// Helpers work on a wide FX_MAXW-bit container; callers slice the low bits they need.
// Contents: state enum, fx_max/fx_min (sign-extended limits), fx_abs/fx_neg (one extra bit).
package fx_pkg;

    // Widest operand the helpers support; callers keep their widths strictly below this.
    localparam int FX_MAXW = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } fx_state_t;

    // Largest positive two's-complement value of width w.
    function automatic logic [FX_MAXW-1:0] fx_max(input int w);
        return (FX_MAXW'(1) << (w - 1)) - FX_MAXW'(1);
    endfunction

    // Most negative two's-complement value of width w, sign-extended.
    function automatic logic [FX_MAXW-1:0] fx_min(input int w);
        return {FX_MAXW{1'b1}} << (w - 1);
    endfunction

    // Magnitude of a sign-extended value; the extra bit keeps the most negative input exact.
    function automatic logic [FX_MAXW:0] fx_abs(input logic [FX_MAXW-1:0] x);
        return x[FX_MAXW-1] ? ({1'b0, ~x} + (FX_MAXW + 1)'(1)) : {1'b0, x};
    endfunction

    // Two's-complement negation at the widened width.
    function automatic logic [FX_MAXW:0] fx_neg(input logic [FX_MAXW:0] m);
        return ~m + (FX_MAXW + 1)'(1);
    endfunction

endpackage

// File: rtl/fx_div_core.sv
// Unsigned restoring divider: one quotient bit per cycle, MSB first, NW steps after start.
// Latency: fin rises NW edges after the start edge; quo is valid while fin is high.
// Backpressure: none; start reloads unconditionally, results persist until the next start.
module fx_div_core #(
    parameter int NW = 8,   // numerator / quotient bits (= iteration count)
    parameter int DW = 8    // divisor magnitude bits
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [NW-1:0] num,
    input  logic [DW-1:0] dvs,
    output logic [NW-1:0] quo,
    output logic          fin
);

    localparam int CW = $clog2(NW + 1);

    logic [DW-1:0] rem;
    logic [DW-1:0] dvs_r;
    logic [NW-1:0] shreg;   // numerator bits shift out the top, quotient bits shift in below
    logic [CW-1:0] cnt;
    logic [DW:0]   trial;
    logic [DW-1:0] diff;
    logic          take;

    // The remainder stays below the divisor, so the subtraction fits in DW bits when taken.
    always_comb begin
        trial = {rem, shreg[NW-1]};
        take  = (trial >= {1'b0, dvs_r});
        diff  = trial[DW-1:0] - dvs_r;
    end

    assign fin = (cnt == CW'(NW));
    assign quo = shreg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem   <= '0;
            dvs_r <= '0;
            shreg <= '0;
            cnt   <= CW'(NW);
        end else if (start) begin
            rem   <= '0;
            dvs_r <= dvs;
            shreg <= num;
            cnt   <= '0;
        end else if (!fin) begin
            rem   <= take ? diff : trial[DW-1:0];
            shreg <= {shreg[NW-2:0], take};
            cnt   <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/fx_div_seq.sv
// Signed Q-format / signed-integer sequential divider with saturation and divide-by-zero flag.
// Latency: out_valid rises ITER+1 edges after the accepting edge (ITER = WIDTH, WIDTH+1 when rounding).
// Backpressure: one operation in flight; in_ready only in IDLE, result held in DONE until out_ready.
// Ports: clk, rst (async, active-high), in_valid/in_ready/dividend/divisor,
//        out_valid/out_ready/quotient/div_zero/sat.
// Build option FX_DIV_ROUND_EN: one guard bit, magnitude rounded half away from zero.
module fx_div_seq
    import fx_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int FRAC   = 6,
    parameter int DWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  dividend,
    input  logic [DWIDTH-1:0] divisor,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  quotient,
    output logic              div_zero,
    output logic              sat
);

`ifdef FX_DIV_ROUND_EN
    localparam int ITER = WIDTH + 1;
`else
    localparam int ITER = WIDTH;
`endif

    localparam logic [FX_MAXW-1:0] MAX_EXT = fx_max(WIDTH);
    localparam logic [FX_MAXW-1:0] MIN_EXT = fx_min(WIDTH);
    localparam logic [WIDTH-1:0]   QMAX    = MAX_EXT[WIDTH-1:0];
    localparam logic [WIDTH-1:0]   QMIN    = MIN_EXT[WIDTH-1:0];
    localparam logic [FX_MAXW:0]   POS_LIM = {1'b0, MAX_EXT};
    localparam logic [FX_MAXW:0]   NEG_LIM = {1'b0, MAX_EXT} + (FX_MAXW + 1)'(1);

    fx_state_t state, state_nx;

    logic              accept;
    logic              load_res;
    logic              neg_r;       // result sign
    logic              a_neg_r;     // dividend sign, picks the div-by-zero limit
    logic              dz_r;
    logic [FX_MAXW:0]  abs_a;
    logic [FX_MAXW:0]  abs_d;
    logic [ITER-1:0]   core_num;
    logic [ITER-1:0]   core_quo;
    logic              core_fin;
    logic [FX_MAXW:0]  mag;
    logic [FX_MAXW:0]  neg_full;
    logic [WIDTH-1:0]  res_q;
    logic              res_sat;
    logic              unused_bits;

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign accept    = in_valid && in_ready;
    assign load_res  = (state == ST_CALC) && core_fin;

    always_comb begin
        abs_a = fx_abs({{(FX_MAXW - WIDTH){dividend[WIDTH-1]}}, dividend});
        abs_d = fx_abs({{(FX_MAXW - DWIDTH){divisor[DWIDTH-1]}}, divisor});
    end

`ifdef FX_DIV_ROUND_EN
    // Trailing zero makes the last iteration produce the guard bit.
    assign core_num = {abs_a[WIDTH-1:0], 1'b0};
`else
    assign core_num = abs_a[WIDTH-1:0];
`endif

    fx_div_core #(
        .NW (ITER),
        .DW (DWIDTH)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .start (accept),
        .num   (core_num),
        .dvs   (abs_d[DWIDTH-1:0]),
        .quo   (core_quo),
        .fin   (core_fin)
    );

    // Magnitude is clamped before the sign goes on; negating zero yields zero, so no -0.
    always_comb begin
        mag = '0;
`ifdef FX_DIV_ROUND_EN
        mag[WIDTH-1:0] = core_quo[ITER-1:1];
        mag = mag + {{FX_MAXW{1'b0}}, core_quo[0]};
`else
        mag[WIDTH-1:0] = core_quo;
`endif
        neg_full = fx_neg(mag);
        res_q    = '0;
        res_sat  = 1'b0;
        if (dz_r) begin
            res_q   = a_neg_r ? QMIN : QMAX;
            res_sat = 1'b1;
        end else if (!neg_r) begin
            if (mag > POS_LIM) begin
                res_q   = QMAX;
                res_sat = 1'b1;
            end else begin
                res_q = mag[WIDTH-1:0];
            end
        end else if (mag > NEG_LIM) begin
            res_q   = QMIN;
            res_sat = 1'b1;
        end else begin
            res_q = neg_full[WIDTH-1:0];
        end
    end

    // FRAC only names the format: an integer divisor leaves the binary point where it is.
    assign unused_bits = ^{abs_a[FX_MAXW:WIDTH], abs_d[FX_MAXW:DWIDTH],
                           neg_full[FX_MAXW:WIDTH], FRAC[0]};

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (accept)    state_nx = ST_CALC;
            ST_CALC: if (core_fin)  state_nx = ST_DONE;
            ST_DONE: if (out_ready) state_nx = ST_IDLE;
            default:                state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            neg_r    <= 1'b0;
            a_neg_r  <= 1'b0;
            dz_r     <= 1'b0;
            quotient <= '0;
            div_zero <= 1'b0;
            sat      <= 1'b0;
        end else begin
            if (accept) begin
                neg_r   <= dividend[WIDTH-1] ^ divisor[DWIDTH-1];
                a_neg_r <= dividend[WIDTH-1];
                dz_r    <= (divisor == '0);
            end
            if (load_res) begin
                quotient <= res_q;
                div_zero <= dz_r;
                sat      <= res_sat;
            end
        end
    end

endmodule

// File: tb/tb_fx_div_seq.sv
// Bench for fx_div_seq (Q2.6 dividend, 8-bit signed divisor): directed and random operations
// against an integer-arithmetic reference, with latency, hold-under-backpressure and async reset.
// Honours FX_DIV_ROUND_EN the same way the design does.
module tb_fx_div_seq;

    localparam int W  = 8;
    localparam int F  = 6;
    localparam int DW = 8;
`ifdef FX_DIV_ROUND_EN
    localparam int ITER = W + 1;
    localparam bit RND  = 1'b1;
`else
    localparam int ITER = W;
    localparam bit RND  = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  dividend = '0;
    logic [DW-1:0] divisor = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  quotient;
    logic          div_zero;
    logic          sat;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fx_div_seq #(.WIDTH(W), .FRAC(F), .DWIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .div_zero  (div_zero),
        .sat       (sat)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: exact rational quotient, truncated or rounded half away from zero on the
    // magnitude, then signed and clamped to the Q range. Returns {div_zero, sat, quotient}.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [DW-1:0] d);
        int ai, di, aa, ad, m, v, vmax, vmin;
        logic s;
        logic [W-1:0] q;
        ai   = $signed(a);
        di   = $signed(d);
        vmax = (1 << (W - 1)) - 1;
        vmin = -(1 << (W - 1));
        if (di == 0) begin
            q = (ai >= 0) ? W'(vmax) : W'(vmin);
            return {1'b1, 1'b1, q};
        end
        aa = (ai < 0) ? -ai : ai;
        ad = (di < 0) ? -di : di;
        if (RND) m = (2 * aa + ad) / (2 * ad);
        else     m = aa / ad;
        v = ((ai < 0) != (di < 0)) ? -m : m;
        s = 1'b0;
        if (v > vmax) begin v = vmax; s = 1'b1; end
        if (v < vmin) begin v = vmin; s = 1'b1; end
        q = W'(v);
        return {1'b0, s, q};
    endfunction

    // Called #1 after a clock edge with the DUT idle; returns in the same phase, idle again.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [DW-1:0] d,
                          input int stall);
        logic [W+1:0] exp;
        int edges;
        exp = model(a, d);
        chk({tag, "/in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        dividend = a;
        divisor  = d;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = W'($urandom);
        divisor  = DW'($urandom);
        chk({tag, "/busy"}, 32'(in_ready), 32'd0);
        edges = 0;
        while (!out_valid && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
        chk({tag, "/latency"}, 32'(edges), 32'(ITER + 1));
        chk({tag, "/quotient"}, 32'(quotient), 32'(exp[W-1:0]));
        chk({tag, "/div_zero"}, 32'(div_zero), 32'(exp[W+1]));
        chk({tag, "/sat"}, 32'(sat), 32'(exp[W]));
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            dividend = W'($urandom);
            divisor  = DW'($urandom);
            @(posedge clk);
            #1;
            chk({tag, "/hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "/hold_ready"}, 32'(in_ready), 32'd0);
            chk({tag, "/hold_q"}, 32'({div_zero, sat, quotient}), 32'(exp));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "/drained"}, 32'(out_valid), 32'd0);
    endtask

    logic [W-1:0]  dir_a [8] = '{8'h7F, 8'hC0, 8'h20, 8'h80, 8'h01, 8'h40, 8'hC0, 8'h80};
    logic [DW-1:0] dir_d [8] = '{8'h03, 8'h03, 8'h03, 8'hFF, 8'hFE, 8'h00, 8'h00, 8'h01};

    initial begin
        #2;
        chk("reset/in_ready", 32'(in_ready), 32'd1);
        chk("reset/out_valid", 32'(out_valid), 32'd0);
        chk("reset/flags_q", 32'({div_zero, sat, quotient}), 32'd0);
        #10 rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++)
            run_op($sformatf("dir%0d", i), dir_a[i], dir_d[i], (i == 0) ? 5 : 0);

        // Result left non-zero with flags set, so the reset checks below are meaningful.
        run_op("pre_rst", 8'h40, 8'h00, 0);
        in_valid = 1'b1;
        dividend = 8'h7F;
        divisor  = 8'h03;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("midrst/out_valid", 32'(out_valid), 32'd0);
        chk("midrst/in_ready", 32'(in_ready), 32'd1);
        chk("midrst/flags_q", 32'({div_zero, sat, quotient}), 32'd0);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        run_op("post_rst", 8'h20, 8'h03, 1);

        for (int i = 0; i < 40; i++) begin
            logic [W-1:0]  ra;
            logic [DW-1:0] rd;
            ra = W'($urandom);
            rd = (i % 10 == 9) ? '0 : DW'($urandom);
            if (i % 7 == 3) rd = DW'($urandom_range(0, 2) == 0 ? 255 : 1);
            run_op($sformatf("rnd%0d", i), ra, rd, int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
